// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl_pkg
// Description : Shared definitions for the LEGv8 ALU issue controller:
//               ALUControl codes, R-type opcode values (instruction bits
//               [31:21]), ALUOp encodings and the issue FSM state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_ctrl_pkg;

    // ALUControl codes understood by the datapath ALU
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    // R-type opcodes, instruction bits [31:21]
    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;

    // ALUOp encodings from the main decoder
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage : alu_issue_ctrl_pkg
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational ALUControl decoder. Maps ALUOp plus the R-type
//               opcode field to a 4-bit ALUControl code and flags opcodes
//               that cannot be decoded. Undecodable cases fall back to ADD
//               so the operation still executes.
// Ports       : opcode      in  11  instruction bits [31:21]
//               aluop       in  2   ALUOp from main decoder
//               alu_control out 4   ALUControl code
//               illegal     out 1   undecodable request
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    input  logic [1:0]  aluop,
    output logic [3:0]  alu_control,
    output logic        illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (aluop)
            ALUOP_MEM: alu_control = ALU_ADD;
            ALUOP_CBZ: alu_control = ALU_PASSB;
            ALUOP_RTYPE: begin
                case (opcode)
                    OP_ADD:  alu_control = ALU_ADD;
                    OP_SUB:  alu_control = ALU_SUB;
                    OP_AND:  alu_control = ALU_AND;
                    OP_ORR:  alu_control = ALU_ORR;
                    default: illegal     = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issue controller in front of the combinational LEGv8 ALU.
//               Accepts one request, registers operands and ALUControl onto
//               the ALU inputs, captures result/zero on the following edge
//               and holds them on a response handshake until consumed.
// Ports       : clk          in  1   clock, rising edge
//               reset        in  1   asynchronous active-low reset
//               req_valid    in  1   request present
//               req_ready    out 1   block can accept a request
//               req_opcode   in  11  instruction bits [31:21]
//               req_aluop    in  2   ALUOp
//               req_a/req_b  in  W   operands
//               alu_a/alu_b  out W   registered ALU operands
//               alu_control  out 4   registered ALUControl
//               alu_result   in  W   ALU result
//               alu_zero     in  1   ALU zero flag
//               rsp_valid    out 1   response present
//               rsp_ready    in  1   consumer accepts response
//               rsp_result   out W   captured result
//               rsp_zero     out 1   captured zero flag
//               rsp_illegal  out 1   request was undecodable
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [10:0]           req_opcode,
    input  logic [1:0]            req_aluop,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_illegal
);

    state_t                r_state;
    logic                  r_req_ready;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [3:0]            r_alu_control;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic                  r_rsp_zero;
    logic                  r_rsp_illegal;

    logic [3:0]            w_dec_control;
    logic                  w_dec_illegal;

    alu_op_decode u_decode (
        .opcode      (req_opcode),
        .aluop       (req_aluop),
        .alu_control (w_dec_control),
        .illegal     (w_dec_illegal)
    );

    // The ALU inputs are only loaded on acceptance, so they stay stable
    // through EXEC and keep their last values afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b1;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= 4'b0000;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_alu_a       <= req_a;
                        r_alu_b       <= req_b;
                        r_alu_control <= w_dec_control;
                        r_rsp_illegal <= w_dec_illegal;
                        r_req_ready   <= 1'b0;
                        r_state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_result <= alu_result;
                    r_rsp_zero   <= alu_zero;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_control;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_illegal = r_rsp_illegal;

endmodule : alu_issue_ctrl
`default_nettype wire
